data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Responder end of the CPU's load/store data port: accepts one word-sized LW/SW request at a time from the CPU datapath, holds it for a programmable number of wait cycles, commits the write or fetches the read word, and answers with a one-cycle `ready` pulse. It replaces the zero-latency mock data memory behind the CPU, so the multi-cycle control FSM can be exercised against realistic memory stalls and bad addresses.

## Interface

- `DEPTH_WORDS`, default 1024: number of 32-bit words stored; must be a power of two, 2 to 65536.
- `LATENCY`, default 2: cycles from request acceptance to `ready`; legal range 1 to 15.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `request`  in  1  initiator asserts to start a transaction; held until `ready` is seen.
- `writeEnable`  in  1  1 = SW (write), 0 = LW (read); sampled with `request`.
- `address`  in  32  byte address, from ALU result `$s + SE(imm)`.
- `dataIn`  in  32  store data (`$t`); sampled with `request` when `writeEnable`=1.
- `ready`  out  1  one-cycle completion pulse.
- `dataOut`  out  32  read data; valid while `ready`=1 for reads, then held.
- `addrError`  out  1  valid with `ready`: the transaction was rejected.

## Operation

- FSM states are IDLE, BUSY and RESP.
- **IDLE:**
  - With `request`=1 at a rising edge, the transaction is accepted. Call that edge E0.
  - On acceptance, latch `address`, `writeEnable` and `dataIn`, and load the wait counter with LATENCY-1.
  - The next state is RESP if LATENCY=1, otherwise BUSY.
- **BUSY:**
  - The counter decrements each edge.
  - When the counter reaches 0 (at edge E0+LATENCY-1), go to RESP.
  - Inputs are ignored while in BUSY.
- **RESP:**
  - Lasts exactly one cycle, then the FSM returns to IDLE.
  - `request` is ignored in this cycle, even if still high.
- **Commit edge:** the edge that enters RESP.
  - Write: `mem[word] <= dataIn_latched`.
  - Read: `dataOut <= mem[word]`.
  - `ready <= 1` and `addrError <= err`.
  - `ready` falls on the following edge.
- **Addressing:**
  - `word = address[log2(DEPTH_WORDS)+1:2]`.
  - `err` = (`address[1:0]` != 0) OR (`address` >= 4*DEPTH_WORDS), using an unsigned compare on all 32 bits.
- **On error:**
  - No memory write occurs.
  - `dataOut` is loaded with 32'hDEADBEEF for both reads and writes.
  - `ready` still pulses, so the initiator never hangs.
- **Holds:**
  - `dataOut` holds its last value until the next commit.
  - A write with no error leaves `dataOut` unchanged.
- **Initial contents:** memory contents are undefined at power-up and are not cleared by `reset`. The bench preloads through hierarchical access or initial writes.

## Timing

- **Reset:** state=IDLE, counter=0, `ready`=0, `addrError`=0, `dataOut`=0. Memory array is untouched.
- **Reset mid-transaction (in BUSY):** the transaction is aborted, with no write and no `ready`.
- **Reset in RESP:** the write already committed at the entry edge stays committed; `ready` is cleared by the reset edge.
- **Latency:** `ready` is high in the cycle after edge E0+LATENCY-1. With LATENCY=1, it is high in the cycle immediately after acceptance.
- **Throughput:** at most one transaction per LATENCY+1 cycles. The earliest next acceptance edge is E0+LATENCY+1, the first edge at which the FSM is in IDLE again.
- **Initiator rule:** keep `request`, `writeEnable`, `address` and `dataIn` stable from assertion until `ready` is sampled. Changes after E0 have no effect, because the values are latched.
- **Back-to-back:** holding `request` high continuously yields a transaction every LATENCY+1 cycles. The same latched values are reused only if the initiator has not updated them.
- **Same-address read after write:** returns the new data, because the write commits before the read can be accepted.
- **Address wrap:** there is no wrap-around. Any address at or beyond 4*DEPTH_WORDS is an error, never an alias.

## Test plan

1. **Reset values:** with `reset`=1 for 2 cycles, then release, `ready`=0, `addrError`=0, `dataOut`=0 and no spurious `ready` for 10 idle cycles.
2. **SW then LW, LATENCY=2:**
   - SW address 28, data 32'd3: `ready` pulses in the 2nd cycle after acceptance, with `addrError`=0.
   - LW address 28: `ready` pulse with `dataOut`=32'd3, which then holds after `ready` falls.
3. **Misaligned and out-of-range, DEPTH_WORDS=1024:**
   - SW to address 30: `ready` with `addrError`=1, `dataOut`=32'hDEADBEEF; a following LW from 28 still returns 3.
   - LW from 4096: `addrError`=1.
   - LW from 4092: `addrError`=0.
4. **Back-to-back throughput:**
   - Hold `request` high for 4 LWs, at LATENCY=1 and LATENCY=3.
   - `ready` pulses exactly every 2 and 4 cycles respectively.
   - Never two consecutive `ready` cycles.
5. **Reset mid-transaction:**
   - SW 32'hA5A5A5A5 to address 8 with LATENCY=4; assert `reset` on the edge after acceptance.
   - Required: no `ready`, and a later LW from 8 returns the prior value.
6. **Input change after acceptance:** change `address` and `dataIn` while BUSY; the committed write uses the values latched at E0.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding word load/store responder with programmable
// wait latency, alignment/range checking and a one-cycle ready pulse.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        request,
   input  logic        writeEnable,
   input  logic [31:0] address,
   input  logic [31:0] dataIn,
   output logic        ready,
   output logic [31:0] dataOut,
   output logic        addrError
);
   localparam int AW = $clog2(DEPTH_WORDS);
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_we;
   logic [31:0] r_addr, r_data;
   logic [31:0] r_mem [DEPTH_WORDS];
   logic        w_idle_go, w_go, w_we, w_err;
   logic [31:0] w_addr, w_data;
   logic [AW-1:0] w_word;
   // With LATENCY=1 the commit happens on the accepting edge, so live inputs are used
   always_comb begin
      w_idle_go = r_state == IDLE && request;
      w_go      = (w_idle_go && LATENCY == 1) || (r_state == BUSY && r_cnt == 4'd1);
      w_addr    = r_state == IDLE ? address : r_addr;
      w_data    = r_state == IDLE ? dataIn : r_data;
      w_we      = r_state == IDLE ? writeEnable : r_we;
      w_word    = w_addr[AW+1:2];
      w_err     = w_addr[1:0] != 2'd0 || w_addr >= 32'(4 * DEPTH_WORDS);
   end
   always_ff @(posedge clk) begin
      if (w_go && w_we && !w_err && !reset) r_mem[w_word] <= w_data;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cnt     <= 4'd0;
         ready     <= 1'b0;
         addrError <= 1'b0;
         dataOut   <= 32'd0;
      end else begin
         ready <= w_go;
         if (w_go) begin
            addrError <= w_err;
            dataOut   <= w_err ? 32'hDEADBEEF : (w_we ? dataOut : r_mem[w_word]);
         end
         if (w_idle_go) begin
            r_addr <= address;
            r_we   <= writeEnable;
            r_data <= dataIn;
            r_cnt  <= 4'(LATENCY - 1);
         end else if (r_state == BUSY) r_cnt <= r_cnt - 4'd1;
         r_state <= w_go ? RESP : w_idle_go ? BUSY : r_state == BUSY ? BUSY : IDLE;
      end
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: four responders at LATENCY 1..4 sharing one bus, checked
// against fixed vectors, corner-case sequences and a random word-memory model.
module tb_data_mem_responder;
   logic        clk, reset, we;
   logic [3:0]  req, rdy, aerr;
   logic [31:0] addr, din;
   logic [31:0] dout [4];
   int          checks, errors;
   logic [31:0] mm [int];
   logic [31:0] pd [4];

   typedef struct {
      bit          we;
      logic [31:0] a;
      logic [31:0] d;
      bit          err;
      logic [31:0] dout;
   } vec_t;
   vec_t tbl [11];

   for (genvar g = 0; g < 4; g++) begin : g_dut
      data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(g + 1)) u_dut (
         .clk(clk), .reset(reset), .request(req[g]), .writeEnable(we),
         .address(addr), .dataIn(din), .ready(rdy[g]), .dataOut(dout[g]),
         .addrError(aerr[g]));
   end

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic bit spec_err(input logic [31:0] a);
      return a[1:0] != 2'd0 || a >= 32'd4096;
   endfunction

   function automatic int key(input int k, input logic [31:0] a);
      return k * 65536 + int'(a[11:2]);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic txn(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input bit chg, input logic [31:0] a2, input logic [31:0] d2,
                      input bit ee, input logic [31:0] ed);
      int lat;
      lat = 0;
      @(negedge clk);
      req[k] = 1; we = w; addr = a; din = d;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (chg && i == 1) begin addr = a2; din = d2; end
         if (rdy[k]) begin lat = i; break; end
      end
      req[k] = 0;
      chk($sformatf("latency[L%0d]", k + 1), lat, k + 1);
      if (lat != 0) begin
         chk($sformatf("addrError[L%0d] a=%h", k + 1, a), aerr[k], ee);
         chk($sformatf("dataOut[L%0d] a=%h", k + 1, a), dout[k], ed);
      end
      @(posedge clk); #1;
      chk($sformatf("ready_fall[L%0d]", k + 1), rdy[k], 0);
      chk($sformatf("dataOut_hold[L%0d]", k + 1), dout[k], ed);
      if (w && !spec_err(a)) mm[key(k, a)] = d;
      pd[k] = ed;
   endtask

   task automatic model_txn(input int k, input bit w, input logic [31:0] a, input logic [31:0] d);
      bit ee;
      ee = spec_err(a);
      txn(k, w, a, d, 0, 0, 0, ee, ee ? 32'hDEADBEEF : w ? pd[k] : mm[key(k, a)]);
   endtask

   task automatic b2b(input int k);
      int cnt, last;
      logic [31:0] ex;
      ex = mm[key(k, 28)];
      cnt = 0; last = 0;
      @(negedge clk);
      req[k] = 1; we = 0; addr = 28;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk); #1;
         if (rdy[k]) begin
            chk($sformatf("b2b_spacing[L%0d]", k + 1), c - last, cnt == 0 ? k + 1 : k + 2);
            chk($sformatf("b2b_data[L%0d]", k + 1), dout[k], ex);
            last = c;
            cnt++;
            if (cnt == 4) begin req[k] = 0; break; end
         end
      end
      req[k] = 0;
      chk($sformatf("b2b_count[L%0d]", k + 1), cnt, 4);
      @(posedge clk); #1;
      chk($sformatf("b2b_fall[L%0d]", k + 1), rdy[k], 0);
      pd[k] = ex;
   endtask

   initial begin
      int seen;
      checks = 0; errors = 0;
      tbl[0]  = '{1, 32'd28,         32'd3,         0, 32'd0};
      tbl[1]  = '{0, 32'd28,         32'd0,         0, 32'd3};
      tbl[2]  = '{1, 32'd30,         32'd99,        1, 32'hDEADBEEF};
      tbl[3]  = '{0, 32'd28,         32'd0,         0, 32'd3};
      tbl[4]  = '{0, 32'd4096,       32'd0,         1, 32'hDEADBEEF};
      tbl[5]  = '{1, 32'd4092,       32'd77,        0, 32'hDEADBEEF};
      tbl[6]  = '{0, 32'd4092,       32'd0,         0, 32'd77};
      tbl[7]  = '{1, 32'd0,          32'h12345678,  0, 32'd77};
      tbl[8]  = '{0, 32'd0,          32'd0,         0, 32'h12345678};
      tbl[9]  = '{0, 32'hFFFFFFFC,   32'd0,         1, 32'hDEADBEEF};
      tbl[10] = '{0, 32'd3,          32'd0,         1, 32'hDEADBEEF};
      for (int k = 0; k < 4; k++) pd[k] = 0;
      reset = 1; req = 0; we = 0; addr = 0; din = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 0;
      for (int k = 0; k < 4; k++) begin
         chk("reset_ready", rdy[k], 0);
         chk("reset_addrError", aerr[k], 0);
         chk("reset_dataOut", dout[k], 0);
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("idle_no_ready", rdy, 0);
      end
      for (int i = 0; i < 11; i++)
         txn(1, tbl[i].we, tbl[i].a, tbl[i].d, 0, 0, 0, tbl[i].err, tbl[i].dout);
      for (int k = 0; k < 4; k++)
         for (int w = 0; w < 16; w++) model_txn(k, 1, 32'(w * 4), $urandom);
      b2b(0);
      b2b(2);
      txn(3, 1, 32'd12, 32'hCAFEF00D, 1, 32'd16, 32'h00000BAD, 0, pd[3]);
      model_txn(3, 0, 32'd12, 0);
      chk("latched_write_data", pd[3], 32'hCAFEF00D);
      model_txn(3, 0, 32'd16, 0);
      @(negedge clk);
      req[3] = 1; we = 1; addr = 8; din = 32'hA5A5A5A5;
      @(posedge clk);
      @(negedge clk);
      reset = 1; req[3] = 0;
      @(posedge clk);
      @(negedge clk);
      reset = 0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (rdy[3]) seen++;
      end
      chk("abort_no_ready", seen, 0);
      chk("abort_dataOut_reset", dout[3], 0);
      for (int k = 0; k < 4; k++) pd[k] = 0;
      model_txn(3, 0, 32'd8, 0);
      for (int k = 0; k < 4; k++)
         for (int n = 0; n < 50; n++) begin
            int r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            a = r < 7 ? 32'($urandom_range(0, 15) * 4) :
                r == 7 ? 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3)) :
                r == 8 ? 32'(4096 + 4 * $urandom_range(0, 1000)) : ($urandom | 32'h00001000);
            model_txn(k, 1'($urandom_range(0, 1)), a, $urandom);
         end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
